// File: rtl/ram_bb_loader.sv
// ram_bb_loader: parses framed USB words into one-hot RAM-bank write strobes and
// keeps the per-channel code-phase delay registers.
`default_nettype none

module ram_bb_loader #(
    parameter logic [15:0] SYNC      = 16'hA55A,
    parameter int          CA_WORDS  = 32,
    parameter int          MSG_WORDS = 47,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] data,
    output logic [15:0] wren,
    output logic [5:0]  wr_addr,
    output logic [9:0]  delay_ca0,
    output logic [9:0]  delay_ca1,
    output logic [9:0]  delay_ca2,
    output logic [9:0]  delay_ca3,
    output logic [9:0]  delay_ca4,
    output logic [9:0]  delay_ca5,
    output logic [9:0]  delay_ca6,
    output logic [9:0]  delay_ca7,
    output logic        load_done,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int         TW      = $clog2(TIMEOUT + 1);
    localparam logic [1:0] T_CA    = 2'd0;
    localparam logic [1:0] T_MSG   = 2'd1;
    localparam logic [1:0] T_DELAY = 2'd2;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [1:0]      pkt_type, pkt_type_n;
    logic [2:0]      chan, chan_n;
    logic [5:0]      idx, idx_n;
    logic [TW-1:0]   timer, timer_n;
    logic            ready_q;
    logic [31:0]     data_n;
    logic [15:0]     wren_n;
    logic [5:0]      wr_addr_n;
    logic            load_done_n;
    logic            busy_n;
    logic            err_evt;
    logic            delay_we;
    logic [9:0]      delay_q [8];

    logic            xfer;
    logic            hdr_ok;
    logic            delay_ok;
    logic [5:0]      last_idx;

    assign s_ready  = ready_q;
    assign xfer     = s_valid & ready_q;
    assign hdr_ok   = (s_data[31:16] == SYNC) && (s_data[15:12] <= 4'd2) && (s_data[11:3] == 9'd0);
    assign delay_ok = (s_data[31:10] == 22'd0) && (s_data[9:0] <= 10'd1022);
    assign last_idx = (pkt_type == T_CA) ? 6'(CA_WORDS - 1) : 6'(MSG_WORDS - 1);

    always_comb begin
        state_n     = state;
        pkt_type_n  = pkt_type;
        chan_n      = chan;
        idx_n       = idx;
        timer_n     = timer;
        data_n      = data;
        wren_n      = 16'd0;
        wr_addr_n   = wr_addr;
        load_done_n = 1'b0;
        err_evt     = 1'b0;
        delay_we    = 1'b0;

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (hdr_ok) begin
                        pkt_type_n = s_data[13:12];
                        chan_n     = s_data[2:0];
                        idx_n      = 6'd0;
                        timer_n    = '0;
                        state_n    = PAYLOAD;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    timer_n = '0;
                    if (pkt_type == T_DELAY) begin
                        if (delay_ok) begin
                            delay_we    = 1'b1;
                            load_done_n = 1'b1;
                        end else begin
                            err_evt = 1'b1;
                        end
                        state_n = IDLE;
                    end else begin
                        // Message strobes live in the upper byte of wren.
                        wren_n    = 16'd1 << {pkt_type == T_MSG, chan};
                        data_n    = s_data;
                        wr_addr_n = idx;
                        idx_n     = idx + 6'd1;
                        if (idx == last_idx) begin
                            load_done_n = 1'b1;
                            state_n     = IDLE;
                        end
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    err_evt = 1'b1;
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Stays high through the cycle after the final payload transfer.
        busy_n = (state_n == PAYLOAD) || ((state == PAYLOAD) && xfer);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pkt_type  <= T_CA;
            chan      <= 3'd0;
            idx       <= 6'd0;
            timer     <= '0;
            ready_q   <= 1'b0;
            data      <= 32'd0;
            wren      <= 16'd0;
            wr_addr   <= 6'd0;
            load_done <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                delay_q[i] <= 10'd0;
            end
        end else begin
            state     <= state_n;
            pkt_type  <= pkt_type_n;
            chan      <= chan_n;
            idx       <= idx_n;
            timer     <= timer_n;
            ready_q   <= 1'b1;
            data      <= data_n;
            wren      <= wren_n;
            wr_addr   <= wr_addr_n;
            load_done <= load_done_n;
            busy      <= busy_n;
            if (err_evt && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (delay_we) begin
                delay_q[chan] <= s_data[9:0];
            end
        end
    end

    assign delay_ca0 = delay_q[0];
    assign delay_ca1 = delay_q[1];
    assign delay_ca2 = delay_q[2];
    assign delay_ca3 = delay_q[3];
    assign delay_ca4 = delay_q[4];
    assign delay_ca5 = delay_q[5];
    assign delay_ca6 = delay_q[6];
    assign delay_ca7 = delay_q[7];

endmodule

`default_nettype wire

// File: tb/tb_ram_bb_loader.sv
// tb_ram_bb_loader: directed self-checking bench for ram_bb_loader.
`default_nettype none

module tb_ram_bb_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] s_data = 32'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] data;
    logic [15:0] wren;
    logic [5:0]  wr_addr;
    logic [9:0]  delay_ca0, delay_ca1, delay_ca2, delay_ca3;
    logic [9:0]  delay_ca4, delay_ca5, delay_ca6, delay_ca7;
    logic        load_done;
    logic        busy;
    logic [7:0]  err_cnt;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ram_bb_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .data      (data),
        .wren      (wren),
        .wr_addr   (wr_addr),
        .delay_ca0 (delay_ca0),
        .delay_ca1 (delay_ca1),
        .delay_ca2 (delay_ca2),
        .delay_ca3 (delay_ca3),
        .delay_ca4 (delay_ca4),
        .delay_ca5 (delay_ca5),
        .delay_ca6 (delay_ca6),
        .delay_ca7 (delay_ca7),
        .load_done (load_done),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single cycle; outputs of that transfer are visible on return.
    task automatic send(input logic [31:0] w);
        s_valid = 1'b1;
        s_data  = w;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_wren", {16'd0, wren}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_addr", {26'd0, wr_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {24'd0, err_cnt}, 32'd0);
        chk("rst_delay", {22'd0, delay_ca5}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", {31'd0, s_ready}, 32'd1);

        // C/A load to channel 3, back-to-back
        send(32'hA55A0003);
        chk("ca3_hdr_wren", {16'd0, wren}, 32'd0);
        chk("ca3_hdr_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            send(32'(i));
            chk("ca3_wren", {16'd0, wren}, 32'h0008);
            chk("ca3_addr", {26'd0, wr_addr}, 32'(i));
            chk("ca3_data", data, 32'(i));
            chk("ca3_done", {31'd0, load_done}, (i == 31) ? 32'd1 : 32'd0);
        end
        chk("ca3_busy_tail", {31'd0, busy}, 32'd1);
        step();
        chk("ca3_wren_off", {16'd0, wren}, 32'd0);
        chk("ca3_done_off", {31'd0, load_done}, 32'd0);
        chk("ca3_busy_off", {31'd0, busy}, 32'd0);

        // MSG load to channel 7, valid toggling every other cycle
        send(32'hA55A1007);
        for (int i = 0; i < 47; i++) begin
            send(32'hC0DE0000 + 32'(i));
            chk("msg7_wren", {16'd0, wren}, 32'h8000);
            chk("msg7_addr", {26'd0, wr_addr}, 32'(i));
            chk("msg7_data", data, 32'hC0DE0000 + 32'(i));
            chk("msg7_done", {31'd0, load_done}, (i == 46) ? 32'd1 : 32'd0);
            step();
            chk("msg7_gap_wren", {16'd0, wren}, 32'd0);
            chk("msg7_gap_done", {31'd0, load_done}, 32'd0);
        end
        chk("msg7_busy_after", {31'd0, busy}, 32'd0);
        chk("msg7_err", {24'd0, err_cnt}, 32'd0);

        // DELAY: in-range value then out-of-range value
        send(32'hA55A2005);
        send(32'h000003FE);
        chk("dly_val", {22'd0, delay_ca5}, 32'd1022);
        chk("dly_done", {31'd0, load_done}, 32'd1);
        chk("dly_wren", {16'd0, wren}, 32'd0);
        chk("dly_other_ch", {22'd0, delay_ca4}, 32'd0);
        send(32'hA55A2005);
        send(32'h000003FF);
        chk("dly_bad_val", {22'd0, delay_ca5}, 32'd1022);
        chk("dly_bad_err", {24'd0, err_cnt}, 32'd1);
        chk("dly_bad_done", {31'd0, load_done}, 32'd0);
        step();

        // Garbage word, then a C/A packet to ch0 whose payload contains a header-like word
        send(32'h12345678);
        chk("garb_err", {24'd0, err_cnt}, 32'd2);
        chk("garb_wren", {16'd0, wren}, 32'd0);
        chk("garb_busy", {31'd0, busy}, 32'd0);
        send(32'hA55A0000);
        for (int i = 0; i < 32; i++) begin
            w = (i == 5) ? 32'hA55A0003 : 32'h00001000 + 32'(i);
            send(w);
            chk("ca0_wren", {16'd0, wren}, 32'h0001);
            chk("ca0_addr", {26'd0, wr_addr}, 32'(i));
            chk("ca0_data", data, w);
            chk("ca0_done", {31'd0, load_done}, (i == 31) ? 32'd1 : 32'd0);
        end
        chk("ca0_err", {24'd0, err_cnt}, 32'd2);

        // Stall after 10 words: abort exactly on the 1024th idle cycle
        send(32'hA55A0002);
        for (int i = 0; i < 10; i++) begin
            send(32'h00002000 + 32'(i));
        end
        repeat (1023) step();
        chk("tmo_busy_before", {31'd0, busy}, 32'd1);
        chk("tmo_err_before", {24'd0, err_cnt}, 32'd2);
        step();
        chk("tmo_busy_after", {31'd0, busy}, 32'd0);
        chk("tmo_err_after", {24'd0, err_cnt}, 32'd3);
        chk("tmo_done", {31'd0, load_done}, 32'd0);
        chk("tmo_wren", {16'd0, wren}, 32'd0);
        send(32'hA55A0004);
        for (int i = 0; i < 32; i++) begin
            send(32'h00003000 + 32'(i));
            chk("ca4_wren", {16'd0, wren}, 32'h0010);
            chk("ca4_addr", {26'd0, wr_addr}, 32'(i));
            chk("ca4_done", {31'd0, load_done}, (i == 31) ? 32'd1 : 32'd0);
        end

        // Reset after 20 MSG words; the remaining 27 words become errors
        send(32'hA55A1001);
        for (int i = 0; i < 20; i++) begin
            send(32'(i));
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_wren", {16'd0, wren}, 32'd0);
        chk("mrst_data", data, 32'd0);
        chk("mrst_addr", {26'd0, wr_addr}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_err", {24'd0, err_cnt}, 32'd0);
        chk("mrst_delay5", {22'd0, delay_ca5}, 32'd0);
        chk("mrst_ready", {31'd0, s_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 20; i < 47; i++) begin
            send(32'(i));
            chk("post_rst_wren", {16'd0, wren}, 32'd0);
            chk("post_rst_done", {31'd0, load_done}, 32'd0);
        end
        chk("post_rst_err", {24'd0, err_cnt}, 32'd27);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
